// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
// Sequential AES InvMixColumns engine. A 128-bit state block is captured in
// IDLE, its four columns are transformed COLS_PER_CYCLE at a time during RUN,
// and the finished block is presented in DONE until the consumer takes it.
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per RUN cycle (1, 2 or 4)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   in_valid   : upstream offers a state block
//   in_ready   : high in IDLE, block can be accepted
//   in_state   : AES state, byte i = bits [8i+7:8i], column c = bytes 4c..4c+3
//   out_valid  : high in DONE, out_state holds the finished result
//   out_ready  : downstream accepts the result
//   out_state  : InvMixColumns result, same byte packing as in_state
//   busy       : high in RUN or DONE
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter always holds a multiple of COLS_PER_CYCLE, so the columns of
  // the current group are exactly those whose index matches the counter once
  // the low bits inside a group are masked off. For 4 columns per cycle the
  // step truncates to 0 and the counter simply stays at 0.
  localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] GROUP_MASK = ~2'(COLS_PER_CYCLE - 1);

  state_e         state, state_next;
  logic [1:0]     counter, counter_next;
  logic [127:0]   blk, blk_next;
  logic [127:0]   transformed;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; coefficients 0e/0b/0d/09 are formed from
  // the x2/x4/x8 multiples of each byte.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return res;
  endfunction

  // Transform only the columns belonging to the group the counter points at.
  always_comb begin
    transformed = blk;
    for (int c = 0; c < 4; c++) begin
      if ((2'(c) & GROUP_MASK) == counter) begin
        transformed[32*c +: 32] = inv_col(blk[32*c +: 32]);
      end
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    blk_next     = blk;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          blk_next     = in_state;
          counter_next = 2'd0;
          state_next   = RUN;
        end
      end
      RUN: begin
        blk_next     = transformed;
        counter_next = counter + STEP;
        if (counter == LAST_GROUP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 2'd0;
      blk     <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      blk     <= blk_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = blk;

endmodule
